// File: rtl/gtxe2_chnl_rx_pkg.sv
// Shared definitions for the GTXE2 channel RX model stages: K28.5 comma
// patterns and the byte-align state encoding.
package gtxe2_chnl_rx_pkg;

  localparam logic [9:0] K28_5_PCOMMA = 10'b0101111100;
  localparam logic [9:0] K28_5_MCOMMA = 10'b1010000011;

  typedef enum logic {
    StUnaligned = 1'b0,
    StAligned   = 1'b1
  } align_state_e;

  function automatic logic is_comma(input logic [9:0] sym, input logic [9:0] pval,
                                    input logic [9:0] mval);
    return (sym == pval) || (sym == mval);
  endfunction

endpackage

// File: rtl/gtxe2_chnl_rx_comma_find.sv
// Priority comma search over the 2*Width alignment window; also reports
// whether the slice at a selected offset is a comma, independent of enables.
module gtxe2_chnl_rx_comma_find
  import gtxe2_chnl_rx_pkg::*;
#(
  parameter int unsigned Width       = 20,
  parameter logic [9:0]  PcommaValue = K28_5_PCOMMA,
  parameter logic [9:0]  McommaValue = K28_5_MCOMMA
) (
  input  logic [2*Width-1:0]         i_win,
  input  logic                       i_pcomma_en,
  input  logic                       i_mcomma_en,
  input  logic [$clog2(Width)-1:0]   i_sel_off,
  output logic                       o_found,
  output logic [$clog2(Width)-1:0]   o_found_off,
  output logic                       o_sel_is_comma
);

  localparam int unsigned OffW = $clog2(Width);

  logic [9:0] w_cand;
  logic [9:0] w_sel;

  // Scan from the top down so the lowest matching offset is the last written.
  always_comb begin
    o_found     = 1'b0;
    o_found_off = '0;
    w_cand      = '0;
    for (int k = int'(Width) - 1; k >= 0; k--) begin
      w_cand = i_win[k +: 10];
      if ((i_pcomma_en && (w_cand == PcommaValue)) ||
          (i_mcomma_en && (w_cand == McommaValue))) begin
        o_found     = 1'b1;
        o_found_off = OffW'(k);
      end
    end
  end

  always_comb begin
    w_sel          = i_win[i_sel_off +: 10];
    o_sel_is_comma = is_comma(w_sel, PcommaValue, McommaValue);
  end

endmodule

// File: rtl/gtxe2_chnl_rx_align.sv
// Comma-detect and byte-align stage of the GTXE2 RX channel model.
// Optional GTXE2_CHNL_RX_ALIGN_SLIDE_EN adds a manual rxslide offset control.
module gtxe2_chnl_rx_align
  import gtxe2_chnl_rx_pkg::*;
#(
  parameter int unsigned Width       = 20,
  parameter logic [9:0]  PcommaValue = K28_5_PCOMMA,
  parameter logic [9:0]  McommaValue = K28_5_MCOMMA
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [Width-1:0] i_indata,
  input  logic             i_in_val,
  input  logic             i_pcommaalignen,
  input  logic             i_mcommaalignen,
`ifdef GTXE2_CHNL_RX_ALIGN_SLIDE_EN
  input  logic             i_rxslide,
`endif
  output logic [Width-1:0] o_outdata,
  output logic             o_out_val,
  output logic             o_byteisaligned,
  output logic             o_byterealign,
  output logic             o_commadet
);

  localparam int unsigned OffW = $clog2(Width);

  align_state_e     r_state;
  align_state_e     w_state_d;
  logic [Width-1:0] r_prev;
  logic [OffW-1:0]  r_offset;
  logic [Width-1:0] r_outdata;
  logic             r_out_val;
  logic             r_realign;
  logic             r_commadet;

  logic [2*Width-1:0] w_win;
  logic               w_found;
  logic [OffW-1:0]    w_found_off;
  logic [OffW-1:0]    w_eo;
  logic [OffW-1:0]    w_offset_d;
  logic               w_eo_is_comma;
  logic               w_realign;

  assign w_win = {i_indata, r_prev};

  gtxe2_chnl_rx_comma_find #(
    .Width       (Width),
    .PcommaValue (PcommaValue),
    .McommaValue (McommaValue)
  ) u_comma_find (
    .i_win          (w_win),
    .i_pcomma_en    (i_pcommaalignen),
    .i_mcomma_en    (i_mcommaalignen),
    .i_sel_off      (w_eo),
    .o_found        (w_found),
    .o_found_off    (w_found_off),
    .o_sel_is_comma (w_eo_is_comma)
  );

  assign w_eo      = w_found ? w_found_off : r_offset;
  assign w_realign = (r_state == StAligned) && w_found && (w_found_off != r_offset);

`ifdef GTXE2_CHNL_RX_ALIGN_SLIDE_EN
  logic r_slide;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_slide <= 1'b0;
    else            r_slide <= i_rxslide;
  end

  // Slide only acts in manual mode; it takes effect from the next accepted word.
  always_comb begin
    w_offset_d = w_eo;
    if (!i_pcommaalignen && !i_mcommaalignen && i_rxslide && !r_slide) begin
      w_offset_d = (r_offset == OffW'(Width - 1)) ? '0 : r_offset + OffW'(1);
    end
  end
`else
  assign w_offset_d = w_eo;
`endif

  // Align FSM: state register, next-state and output decode.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= StUnaligned;
    else            r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    if (i_in_val && w_found) w_state_d = StAligned;
  end

  always_comb begin
    o_byteisaligned = (r_state == StAligned);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_prev     <= '0;
      r_offset   <= '0;
      r_outdata  <= '0;
      r_out_val  <= 1'b0;
      r_realign  <= 1'b0;
      r_commadet <= 1'b0;
    end else begin
      r_out_val  <= i_in_val;
      r_realign  <= 1'b0;
      r_commadet <= 1'b0;
      if (i_in_val) begin
        r_outdata  <= w_win[w_eo +: Width];
        r_prev     <= i_indata;
        r_offset   <= w_offset_d;
        r_realign  <= w_realign;
        r_commadet <= w_eo_is_comma;
      end
    end
  end

  assign o_outdata     = r_outdata;
  assign o_out_val     = r_out_val;
  assign o_byterealign = r_realign;
  assign o_commadet    = r_commadet;

endmodule
